// File: rtl/multi_frame_er_scheduler.sv
// Multi-frame error-reconciliation scheduler.
// Launches the A/B ER cores once per frame, waits for both cores to finish (or for a
// timeout), folds the per-frame leaked-info / error-count figures into saturating run
// totals and steps through NUM_FRAMES frames with a ping-pong sifted-key bank select.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   start_switch                    run request, rising edge in IDLE starts a run
//   frame_round                     current frame index
//   sifted_key_addr_index           sifted-key bank select, toggles every frame
//   frame_start                     one-cycle launch pulse to the ER cores
//   A/B_finish_error_reconciliation ER core completion pulses
//   A/B_error_verification_fail     ER core verification failure pulses
//   A_er_leaked_info/error_count    per-frame figures, captured on A_er_parameter_valid
//   total_leaked_info/error_count   saturating run totals
//   failed_frame_count              frames that failed, timed out or gave no figures
//   busy, run_done, timeout_flag    status: not idle, end-of-run pulse, a frame timed out
module multi_frame_er_scheduler #(
  parameter int unsigned NUM_FRAMES        = 64,
  parameter int unsigned FRAME_ROUND_WIDTH = 6,
  parameter int unsigned LEAKED_W          = 16,
  parameter int unsigned ERRCNT_W          = 12,
  parameter int unsigned ACC_W             = 24,
  parameter int unsigned TIMEOUT_CYCLES    = 1 << 20
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_switch,
  output logic [FRAME_ROUND_WIDTH-1:0] frame_round,
  output logic                         sifted_key_addr_index,
  output logic                         frame_start,
  input  logic                         A_finish_error_reconciliation,
  input  logic                         B_finish_error_reconciliation,
  input  logic                         A_error_verification_fail,
  input  logic                         B_error_verification_fail,
  input  logic [LEAKED_W-1:0]          A_er_leaked_info,
  input  logic [ERRCNT_W-1:0]          A_er_error_count,
  input  logic                         A_er_parameter_valid,
  output logic [ACC_W-1:0]             total_leaked_info,
  output logic [ACC_W-1:0]             total_error_count,
  output logic [FRAME_ROUND_WIDTH:0]   failed_frame_count,
  output logic                         busy,
  output logic                         run_done,
  output logic                         timeout_flag
);

  localparam int unsigned WaitW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Operand width wide enough for any accumulator or per-frame figure.
  localparam int unsigned OpW = (ACC_W > LEAKED_W) ?
                                ((ACC_W > ERRCNT_W) ? ACC_W : ERRCNT_W) :
                                ((LEAKED_W > ERRCNT_W) ? LEAKED_W : ERRCNT_W);
  localparam int unsigned SumW = OpW + 1;

  typedef enum logic [2:0] {
    StIdle, StLaunch, StWait, StAccum, StNext, StDone
  } state_e;

  state_e                       r_state;
  logic                         r_start_prev;
  logic [FRAME_ROUND_WIDTH-1:0] r_frame_round;
  logic                         r_sel;
  logic                         r_frame_start;
  logic                         r_run_done;
  logic                         r_busy;
  logic                         r_a_done;
  logic                         r_b_done;
  logic                         r_fail;
  logic                         r_par_seen;
  logic [LEAKED_W-1:0]          r_leaked;
  logic [ERRCNT_W-1:0]          r_errcnt;
  logic [WaitW-1:0]             r_wait_cnt;
  logic [ACC_W-1:0]             r_total_leaked;
  logic [ACC_W-1:0]             r_total_err;
  logic [FRAME_ROUND_WIDTH:0]   r_failed_cnt;
  logic                         r_timeout_flag;

  logic w_start_edge;
  logic w_a_complete;
  logic w_b_complete;

  assign w_start_edge = start_switch & ~r_start_prev;
  // A completion pulse counts in the same cycle it arrives, not only once it is latched.
  assign w_a_complete = r_a_done | A_finish_error_reconciliation;
  assign w_b_complete = r_b_done | B_finish_error_reconciliation;

  function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] acc,
                                               input logic [OpW-1:0]   inc);
    logic [SumW-1:0] sum;
    sum = SumW'(acc) + SumW'(inc);
    if (sum > SumW'({ACC_W{1'b1}})) begin
      return {ACC_W{1'b1}};
    end
    return sum[ACC_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      // Reset to "seen high" so a switch held high through reset needs a fresh low first.
      r_start_prev   <= 1'b1;
      r_frame_round  <= '0;
      r_sel          <= 1'b0;
      r_frame_start  <= 1'b0;
      r_run_done     <= 1'b0;
      r_busy         <= 1'b0;
      r_a_done       <= 1'b0;
      r_b_done       <= 1'b0;
      r_fail         <= 1'b0;
      r_par_seen     <= 1'b0;
      r_leaked       <= '0;
      r_errcnt       <= '0;
      r_wait_cnt     <= '0;
      r_total_leaked <= '0;
      r_total_err    <= '0;
      r_failed_cnt   <= '0;
      r_timeout_flag <= 1'b0;
    end else begin
      r_start_prev  <= start_switch;
      r_frame_start <= 1'b0;
      r_run_done    <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_start_edge) begin
            r_state        <= StLaunch;
            r_busy         <= 1'b1;
            r_frame_start  <= 1'b1;
            r_frame_round  <= '0;
            r_sel          <= 1'b0;
            r_total_leaked <= '0;
            r_total_err    <= '0;
            r_failed_cnt   <= '0;
            r_timeout_flag <= 1'b0;
          end
        end
        StLaunch: begin
          r_a_done   <= 1'b0;
          r_b_done   <= 1'b0;
          r_fail     <= 1'b0;
          r_par_seen <= 1'b0;
          r_wait_cnt <= '0;
          r_state    <= StWait;
        end
        StWait: begin
          if (A_finish_error_reconciliation) r_a_done <= 1'b1;
          if (B_finish_error_reconciliation) r_b_done <= 1'b1;
          if (A_error_verification_fail || B_error_verification_fail) r_fail <= 1'b1;
          if (A_er_parameter_valid) begin
            r_leaked   <= A_er_leaked_info;
            r_errcnt   <= A_er_error_count;
            r_par_seen <= 1'b1;
          end
          // Completion takes priority over a timeout landing in the same cycle.
          if (w_a_complete && w_b_complete) begin
            r_state <= StAccum;
          end else if (r_wait_cnt == WaitW'(TIMEOUT_CYCLES - 1)) begin
            r_fail         <= 1'b1;
            r_timeout_flag <= 1'b1;
            r_state        <= StAccum;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        StAccum: begin
          // Leakage is disclosed even on a failed frame, so it is always charged.
          if (r_par_seen) begin
            r_total_leaked <= sat_add(r_total_leaked, OpW'(r_leaked));
          end
          if (r_par_seen && !r_fail) begin
            r_total_err <= sat_add(r_total_err, OpW'(r_errcnt));
          end
          if (r_fail || !r_par_seen) begin
            r_failed_cnt <= r_failed_cnt + 1'b1;
          end
          r_state <= StNext;
        end
        StNext: begin
          if (r_frame_round == FRAME_ROUND_WIDTH'(NUM_FRAMES - 1)) begin
            r_run_done <= 1'b1;
            r_state    <= StDone;
          end else begin
            r_frame_round <= r_frame_round + 1'b1;
            r_sel         <= ~r_sel;
            r_frame_start <= 1'b1;
            r_state       <= StLaunch;
          end
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign frame_round           = r_frame_round;
  assign sifted_key_addr_index = r_sel;
  assign frame_start           = r_frame_start;
  assign total_leaked_info     = r_total_leaked;
  assign total_error_count     = r_total_err;
  assign failed_frame_count    = r_failed_cnt;
  assign busy                  = r_busy;
  assign run_done              = r_run_done;
  assign timeout_flag          = r_timeout_flag;

endmodule

// File: tb/tb_multi_frame_er_scheduler.sv
// Randomized scoreboard bench for multi_frame_er_scheduler.
// A driver plans each run frame by frame, pushes the expected launch and end-of-run
// records, then plays the ER core pulses; a negedge monitor pops and compares whenever
// the DUT raises frame_start or run_done.
module tb_multi_frame_er_scheduler;

  localparam int NF  = 4;
  localparam int FRW = 2;
  localparam int LW  = 16;
  localparam int EW  = 12;
  localparam int AW  = 10;
  localparam int TO  = 50;
  localparam longint AMAX = (64'd1 << AW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start_switch;
  logic [FRW-1:0] frame_round;
  logic           sel;
  logic           frame_start;
  logic           a_fin, b_fin, a_vf, b_vf, par_v;
  logic [LW-1:0]  leaked;
  logic [EW-1:0]  errc;
  logic [AW-1:0]  tot_leaked, tot_err;
  logic [FRW:0]   failed_cnt;
  logic           busy, run_done, timeout_flag;

  multi_frame_er_scheduler #(
    .NUM_FRAMES(NF), .FRAME_ROUND_WIDTH(FRW), .LEAKED_W(LW), .ERRCNT_W(EW),
    .ACC_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_switch(start_switch),
    .frame_round(frame_round), .sifted_key_addr_index(sel), .frame_start(frame_start),
    .A_finish_error_reconciliation(a_fin), .B_finish_error_reconciliation(b_fin),
    .A_error_verification_fail(a_vf), .B_error_verification_fail(b_vf),
    .A_er_leaked_info(leaked), .A_er_error_count(errc), .A_er_parameter_valid(par_v),
    .total_leaked_info(tot_leaked), .total_error_count(tot_err),
    .failed_frame_count(failed_cnt), .busy(busy), .run_done(run_done),
    .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int sel; int gap; } launch_t;
  typedef struct { longint lk; longint ec; int failed; int tflag; int gap; } run_t;

  launch_t exp_launch[$];
  run_t    exp_run[$];
  launch_t ml;
  run_t    mr;
  run_t    last_run;

  int n_cmp = 0;
  int n_bad = 0;
  longint cyc = 0;
  longint last_launch = 0;

  // Frame plan: mode 0 A then B, 1 same cycle, 2 B then A, 3 verification fail,
  // 4 timeout (B never finishes), 5 no parameters delivered.
  int p_mode[NF], p_ta[NF], p_tb[NF], p_vf[NF], p_tv[NF], p_par[NF];
  int p_tp1[NF], p_tp2[NF], p_lk[NF], p_ec[NF], p_cdone[NF];

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic finish_sim();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic budget_fail(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no response within cycle budget", what);
    finish_sim();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_er();
    a_fin = 1'b0; b_fin = 1'b0; a_vf = 1'b0; b_vf = 1'b0; par_v = 1'b0;
  endtask

  // Monitor: compares against the scoreboard queues whenever the DUT presents an event.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (frame_start) begin
        if (exp_launch.size() == 0) begin
          check("unexpected_frame_start", 1, 0);
        end else begin
          ml = exp_launch.pop_front();
          check("launch_frame_round", frame_round, ml.idx);
          check("launch_bank_sel", sel, ml.sel);
          check("launch_busy", busy, 1);
          if (ml.gap != 0) check("launch_gap", cyc - last_launch, ml.gap);
        end
        last_launch = cyc;
      end
      if (run_done) begin
        if (exp_run.size() == 0) begin
          check("unexpected_run_done", 1, 0);
        end else begin
          mr = exp_run.pop_front();
          check("total_leaked", tot_leaked, mr.lk);
          check("total_error", tot_err, mr.ec);
          check("failed_frames", failed_cnt, mr.failed);
          check("timeout_flag", timeout_flag, mr.tflag);
          check("done_frame_round", frame_round, NF - 1);
          check("done_gap", cyc - last_launch, mr.gap);
        end
      end
    end
  end

  function automatic void plan_random();
    for (int f = 0; f < NF; f++) begin
      p_mode[f] = int'($urandom_range(0, 5));
      p_vf[f] = 0;
      p_tv[f] = 0;
      p_par[f] = (p_mode[f] != 5) ? 1 : 0;
      case (p_mode[f])
        1: begin p_ta[f] = int'($urandom_range(1, 15)); p_tb[f] = p_ta[f]; end
        2: begin p_tb[f] = int'($urandom_range(1, 12)); p_ta[f] = p_tb[f] + int'($urandom_range(1, 12)); end
        4: begin p_ta[f] = int'($urandom_range(1, 40)); p_tb[f] = 0; end
        default: begin p_ta[f] = int'($urandom_range(1, 12)); p_tb[f] = p_ta[f] + int'($urandom_range(1, 12)); end
      endcase
      p_cdone[f] = (p_mode[f] == 4) ? TO : ((p_ta[f] > p_tb[f]) ? p_ta[f] : p_tb[f]);
      if (p_mode[f] == 3) begin
        p_vf[f] = int'($urandom_range(1, 2));
        p_tv[f] = int'($urandom_range(1, p_cdone[f]));
      end
      p_tp2[f] = int'($urandom_range(1, p_cdone[f]));
      p_tp1[f] = int'($urandom_range(1, p_tp2[f]));
      p_lk[f] = int'($urandom_range(0, 400));
      p_ec[f] = int'($urandom_range(0, 300));
    end
  endfunction

  function automatic void plan_fixed(input int mode, input int ta, input int tb,
                                     input int lk, input int ec);
    for (int f = 0; f < NF; f++) begin
      p_mode[f] = mode; p_ta[f] = ta; p_tb[f] = tb; p_vf[f] = 0; p_tv[f] = 0;
      p_par[f] = 1; p_tp1[f] = 2; p_tp2[f] = 3; p_lk[f] = lk; p_ec[f] = ec;
      p_cdone[f] = (ta > tb) ? ta : tb;
    end
  endfunction

  // Reference model: whole-run arithmetic from the frame plan.
  function automatic void push_expect();
    longint sum_lk = 0;
    longint sum_ec = 0;
    int failed = 0;
    int tflag = 0;
    for (int f = 0; f < NF; f++) begin
      bit fail;
      fail = (p_vf[f] != 0) || (p_mode[f] == 4);
      if (p_par[f] != 0) sum_lk += p_lk[f];
      if (p_par[f] != 0 && !fail) sum_ec += p_ec[f];
      if (fail || p_par[f] == 0) failed++;
      if (p_mode[f] == 4) tflag = 1;
      exp_launch.push_back('{idx: f, sel: f % 2, gap: (f == 0) ? 0 : p_cdone[f-1] + 3});
    end
    last_run = '{lk: (sum_lk > AMAX) ? AMAX : sum_lk, ec: (sum_ec > AMAX) ? AMAX : sum_ec,
                 failed: failed, tflag: tflag, gap: p_cdone[NF-1] + 3};
    exp_run.push_back(last_run);
  endfunction

  task automatic drive_frame(input int f, input bit toggle);
    for (int c = 1; c <= p_cdone[f]; c++) begin
      tick();
      a_fin = (c == p_ta[f]);
      b_fin = (c == p_tb[f]);
      a_vf  = (p_vf[f] == 1) && (c == p_tv[f]);
      b_vf  = (p_vf[f] == 2) && (c == p_tv[f]);
      par_v = (p_par[f] != 0) && (c == p_tp1[f] || c == p_tp2[f]);
      if (c == p_tp2[f]) begin
        leaked = LW'(p_lk[f]);
        errc   = EW'(p_ec[f]);
      end else begin
        leaked = LW'($urandom);
        errc   = EW'($urandom);
      end
      // A start edge while busy must not disturb the run.
      if (toggle && c == 1) start_switch = 1'b0;
      if (toggle && c == 2) start_switch = 1'b1;
    end
    tick();
    clear_er();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frame_round"}, frame_round, 0);
    check({tag, "_bank_sel"}, sel, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_total_leaked"}, tot_leaked, 0);
    check({tag, "_total_error"}, tot_err, 0);
    check({tag, "_failed"}, failed_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_run_done"}, run_done, 0);
    check({tag, "_timeout_flag"}, timeout_flag, 0);
  endtask

  task automatic drive_run(input bit abort, input bit toggle);
    bit ok;
    push_expect();
    tick();
    start_switch = 1'b1;
    for (int f = 0; f < NF; f++) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        tick();
        ok = frame_start;
      end
      if (!ok) budget_fail("wait_frame_start");
      if (abort && f == 2) begin
        tick();
        tick();
        start_switch = 1'b1;
        rst = 1'b1;
        exp_launch.delete();
        exp_run.delete();
        tick();
        check_all_zero("midrun_reset");
        rst = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("held_start_no_restart_busy", busy, 0);
        check("held_start_no_restart_round", frame_round, 0);
        start_switch = 1'b0;
        return;
      end
      drive_frame(f, toggle && f == 1);
    end
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = run_done;
    end
    if (!ok) budget_fail("wait_run_done");
    start_switch = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("idle_busy", busy, 0);
    check("idle_hold_leaked", tot_leaked, last_run.lk);
    check("idle_hold_error", tot_err, last_run.ec);
    check("idle_hold_failed", failed_cnt, last_run.failed);
    check("idle_hold_round", frame_round, NF - 1);
  endtask

  initial begin
    #500000;
    budget_fail("global_watchdog");
  end

  initial begin
    rst = 1'b1;
    start_switch = 1'b1;
    leaked = '0;
    errc = '0;
    clear_er();
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    // Switch held high through reset release must not start a run.
    for (int i = 0; i < 5; i++) tick();
    check("release_held_start_busy", busy, 0);
    start_switch = 1'b0;

    plan_fixed(0, 5, 15, 100, 5);
    drive_run(1'b0, 1'b0);
    plan_fixed(1, 4, 4, 600, 700);
    drive_run(1'b0, 1'b1);
    for (int r = 0; r < 12; r++) begin
      plan_random();
      drive_run(1'b0, 1'($urandom_range(0, 1)));
    end
    plan_random();
    drive_run(1'b1, 1'b0);
    plan_random();
    drive_run(1'b0, 1'b0);

    for (int i = 0; i < 5; i++) tick();
    check("leftover_launch_expectations", exp_launch.size(), 0);
    check("leftover_run_expectations", exp_run.size(), 0);
    finish_sim();
  end

endmodule
